// File: rtl/arcade_input_pkg.sv
// Shared constants for the Moon Cresta input conditioning block:
// joystick bit map, PS/2 scan codes and the credit sequencer states.
package arcade_input_pkg;

   localparam int JB_RIGHT  = 32'd0;
   localparam int JB_LEFT   = 32'd1;
   localparam int JB_DOWN   = 32'd2;
   localparam int JB_UP     = 32'd3;
   localparam int JB_FIRE   = 32'd4;
   localparam int JB_START1 = 32'd5;
   localparam int JB_START2 = 32'd6;
   localparam int JB_COIN   = 32'd7;

   // Arrow keys match on the low 8 bits so the extended flag is ignored.
   localparam logic [7:0] KC_UP    = 8'h75;
   localparam logic [7:0] KC_DOWN  = 8'h72;
   localparam logic [7:0] KC_LEFT  = 8'h6B;
   localparam logic [7:0] KC_RIGHT = 8'h74;
   localparam logic [8:0] KC_SPACE = 9'h029;
   localparam logic [8:0] KC_CTRL  = 9'h014;
   localparam logic [8:0] KC_F1    = 9'h005;
   localparam logic [8:0] KC_F2    = 9'h006;
   localparam logic [8:0] KC_COIN  = 9'h02E;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_COIN  = 2'd1,
      SEQ_GAP   = 2'd2,
      SEQ_START = 2'd3
   } seq_state_t;

endpackage

// File: rtl/coin_start_seq.sv
// Credit sequencer: on a start request it emits a timed coin pulse, an idle
// gap, then a start pulse for the player that asked.
module coin_start_seq
   import arcade_input_pkg::*;
#(
   parameter int unsigned COIN_LEN  = 32'd1200000,
   parameter int unsigned GAP_LEN   = 32'd2400000,
   parameter int unsigned START_LEN = 32'd1200000,
   parameter int unsigned CW        = 32'd24
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic s1_rise,
   input  logic s2_rise,
   output logic coin,
   output logic start1,
   output logic start2,
   output logic busy
);

   localparam logic [CW-1:0] COIN_LOAD  = CW'(COIN_LEN - 32'd1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 32'd1);
   localparam logic [CW-1:0] START_LOAD = CW'(START_LEN - 32'd1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(32'd0);

   seq_state_t      state_r, state_s;
   logic [CW-1:0]   count_r, count_s;
   logic            player_r, player_s;   // 0 = player 1, 1 = player 2

   // State, counter and player latch registers.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_r  <= SEQ_IDLE;
         count_r  <= CNT_ZERO;
         player_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         player_r <= player_s;
      end
   end

   // Next-state and per-state outputs; requests outside IDLE are dropped.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      player_s = player_r;
      coin     = 1'b0;
      start1   = 1'b0;
      start2   = 1'b0;
      busy     = (state_r != SEQ_IDLE);
      case (state_r)
         SEQ_IDLE: begin
            if (s1_rise || s2_rise) begin
               player_s = ~s1_rise;
               count_s  = COIN_LOAD;
               state_s  = SEQ_COIN;
            end else begin
               state_s  = SEQ_IDLE;
            end
         end
         SEQ_COIN: begin
            coin = 1'b1;
            if (count_r == CNT_ZERO) begin
               count_s = GAP_LOAD;
               state_s = SEQ_GAP;
            end else begin
               count_s = count_r - CNT_ONE;
            end
         end
         SEQ_GAP: begin
            if (count_r == CNT_ZERO) begin
               count_s = START_LOAD;
               state_s = SEQ_START;
            end else begin
               count_s = count_r - CNT_ONE;
            end
         end
         SEQ_START: begin
            start1 = ~player_r;
            start2 = player_r;
            if (count_r == CNT_ZERO) begin
               state_s = SEQ_IDLE;
            end else begin
               count_s = count_r - CNT_ONE;
            end
         end
         default: begin
            state_s = SEQ_IDLE;
            count_s = CNT_ZERO;
         end
      endcase
   end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player input conditioning for the Moon Cresta core: PS/2 key decode,
// joystick merge, orientation remap and sequenced coin/start credit.
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int unsigned COIN_LEN  = 32'd1200000,
   parameter int unsigned GAP_LEN   = 32'd2400000,
   parameter int unsigned START_LEN = 32'd1200000,
   parameter int unsigned CW        = 32'd24
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        horz,
   output logic [6:0]  p1_csjudlr,
   output logic [6:0]  p2_csjudlr,
   output logic        seq_busy
);

   logic        toggle_r, primed_r, key_evt_s;
   logic        key_up_r, key_down_r, key_left_r, key_right_r;
   logic        key_space_r, key_ctrl_r, key_f1_r, key_f2_r, key_coin_r;
   logic [15:0] joy_s;
   logic        raw_up_s, raw_down_s, raw_left_s, raw_right_s;
   logic        up_s, down_s, left_s, right_s, fire_s, coin_s;
   logic        s1_s, s2_s, s1_prev_r, s2_prev_r;
   logic        seq_coin_s, seq_start1_s, seq_start2_s, seq_busy_s;
   logic        unused_joy_s;

   assign key_evt_s    = primed_r && (ps2_key[10] != toggle_r);
   assign unused_joy_s = ^joy_s[15:8];

   // PS/2 event detection and held-key registers.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         toggle_r    <= 1'b0;
         primed_r    <= 1'b0;
         key_up_r    <= 1'b0;
         key_down_r  <= 1'b0;
         key_left_r  <= 1'b0;
         key_right_r <= 1'b0;
         key_space_r <= 1'b0;
         key_ctrl_r  <= 1'b0;
         key_f1_r    <= 1'b0;
         key_f2_r    <= 1'b0;
         key_coin_r  <= 1'b0;
      end else begin
         toggle_r <= ps2_key[10];
         primed_r <= 1'b1;
         if (key_evt_s) begin
            if      (ps2_key[7:0] == KC_UP)    key_up_r    <= ps2_key[9];
            else if (ps2_key[7:0] == KC_DOWN)  key_down_r  <= ps2_key[9];
            else if (ps2_key[7:0] == KC_LEFT)  key_left_r  <= ps2_key[9];
            else if (ps2_key[7:0] == KC_RIGHT) key_right_r <= ps2_key[9];
            else if (ps2_key[8:0] == KC_SPACE) key_space_r <= ps2_key[9];
            else if (ps2_key[8:0] == KC_CTRL)  key_ctrl_r  <= ps2_key[9];
            else if (ps2_key[8:0] == KC_F1)    key_f1_r    <= ps2_key[9];
            else if (ps2_key[8:0] == KC_F2)    key_f2_r    <= ps2_key[9];
            else if (ps2_key[8:0] == KC_COIN)  key_coin_r  <= ps2_key[9];
            else                               key_coin_r  <= key_coin_r;
         end
      end
   end

   // Merge keyboard with both pads and apply the orientation remap.
   always_comb begin
      joy_s       = joystick_0 | joystick_1;
      raw_up_s    = key_up_r    | joy_s[JB_UP];
      raw_down_s  = key_down_r  | joy_s[JB_DOWN];
      raw_left_s  = key_left_r  | joy_s[JB_LEFT];
      raw_right_s = key_right_r | joy_s[JB_RIGHT];
      fire_s      = key_space_r | key_ctrl_r | joy_s[JB_FIRE];
      s1_s        = key_f1_r | joy_s[JB_START1];
      s2_s        = key_f2_r | joy_s[JB_START2];
      if (horz) begin
         up_s    = raw_left_s;
         down_s  = raw_right_s;
         left_s  = raw_down_s;
         right_s = raw_up_s;
      end else begin
         up_s    = raw_up_s;
         down_s  = raw_down_s;
         left_s  = raw_left_s;
         right_s = raw_right_s;
      end
      coin_s = seq_coin_s | key_coin_r | joy_s[JB_COIN];
   end

   // Previous start levels for rising-edge detection.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         s1_prev_r <= 1'b0;
         s2_prev_r <= 1'b0;
      end else begin
         s1_prev_r <= s1_s;
         s2_prev_r <= s2_s;
      end
   end

   coin_start_seq #(
      .COIN_LEN  (COIN_LEN),
      .GAP_LEN   (GAP_LEN),
      .START_LEN (START_LEN),
      .CW        (CW)
   ) u_seq (
      .clk_sys (clk_sys),
      .rst     (RESET),
      .s1_rise (s1_s & ~s1_prev_r),
      .s2_rise (s2_s & ~s2_prev_r),
      .coin    (seq_coin_s),
      .start1  (seq_start1_s),
      .start2  (seq_start2_s),
      .busy    (seq_busy_s)
   );

   // Registered core-facing outputs.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         p1_csjudlr <= 7'b0000000;
         p2_csjudlr <= 7'b0000000;
         seq_busy   <= 1'b0;
      end else begin
         p1_csjudlr <= {coin_s, seq_start1_s, fire_s, up_s, down_s, left_s, right_s};
         p2_csjudlr <= {1'b0,   seq_start2_s, fire_s, up_s, down_s, left_s, right_s};
         seq_busy   <= seq_busy_s;
      end
   end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Conditions player inputs for the Moon Cresta core and drives its P1_CSJUDLR / P2_CSJUDLR buses; sits between hps_io (ps2_key, joystick_0/1) and the galaxian core.
- Decodes PS/2 key events into held button states and applies the Vert/Horz orientation remap.
- Replaces the raw "coin = start1|start2" with a sequenced credit: timed coin pulse, gap, then start pulse for the requested player.

Parameters:
- COIN_LEN, 1200000, coin assert length in clk_sys cycles (100 ms at 12 MHz).
- GAP_LEN, 2400000, idle cycles between coin release and start assert.
- START_LEN, 1200000, start assert length in cycles.
- CW, 24, width of the sequencer counter; must hold max(COIN_LEN, GAP_LEN, START_LEN).

Ports:
- clk_sys  in  1  system clock (12 MHz).
- RESET  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = extended).
- joystick_0  in  16  player-1 pad: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin.
- joystick_1  in  16  player-2 pad, same bit map.
- horz  in  1  1 = horizontal orientation remap (status[2]).
- p1_csjudlr  out  7  {coin, start1, fire, up, down, left, right} to core P1.
- p2_csjudlr  out  7  {1'b0, start2, fire, up, down, left, right} to core P2.
- seq_busy  out  1  high while the credit sequencer is not IDLE.

Behaviour:
- Reset: all outputs 0, all key registers 0, sequencer IDLE, counter 0, primed=0.
- Key events:
  - A decode occurs on the edge where ps2_key[10] differs from its registered copy.
  - The first cycle after reset only loads the copy (primed<=1) and decodes nothing, so no spurious event.
  - Codes: X75 up, X72 down, X6B left, X74 right (bit 8 ignored); 029 space-fire, 014 ctrl-fire; 005 F1 start1; 006 F2 start2; 02E '5' coin.
  - Key register <= ps2_key[9]. Space and ctrl use separate registers; fire = OR of both, so releasing one does not clear the other.
  - Unlisted codes are ignored.
- Merge: joy = joystick_0 | joystick_1; each raw control = key reg | joy bit.
- Orientation, applied when horz=1: up<=left, down<=right, left<=down, right<=up. When horz=0, direct.
- Start edge detect:
  - s1 = key F1 | joy[5]; s2 = key F2 | joy[6]; rising edges are taken against registered previous values.
- Sequencer FSM, IDLE -> COIN -> GAP -> START -> IDLE:
  - IDLE: on a rise of s1 or s2, latch player (s1 has priority if both rise in the same cycle), load counter with COIN_LEN-1, go to COIN.
  - COIN: seq coin=1; at counter 0, load GAP_LEN-1 and go to GAP.
  - GAP: all seq outputs 0; at counter 0, load START_LEN-1 and go to START.
  - START: seq start(player)=1; at counter 0, go to IDLE.
  - Each state lasts exactly its parameter length in cycles.
  - Start edges outside IDLE are discarded, not queued. A start held through the whole sequence does not retrigger; only a new rise does.
  - Reset mid-sequence forces IDLE with all outputs 0 on the next output update.
- Outputs:
  - p1 coin = seq coin | key '5' | joy[7]; start1 = seq start1; start2 = seq start2.
  - Directional and fire bits are shared by p1 and p2.
  - p2 bit 6 is tied 0.
  - All outputs are registered.
- Latency:
  - joystick -> output: 1 cycle.
  - ps2 toggle change -> output: 2 cycles.
  - start rise -> coin asserted: 2 cycles.
- seq_busy = (state != IDLE), registered in step with the outputs.

Decomposition:
- Package arcade_input_pkg holds:
  - joystick bit indices (JB_RIGHT..JB_COIN).
  - PS/2 code constants (KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT, KC_SPACE, KC_CTRL, KC_F1, KC_F2, KC_COIN).
  - The sequencer state enum seq_state_t.
- One sub-module, coin_start_seq, contains the FSM, counter and player latch. Its inputs are s1_rise/s2_rise; its outputs are coin/start1/start2/busy.

Test Plan:
- Reset with ps2_key[10]=1, then hold 20 cycles -> all outputs 0, no key latched.
- Toggle ps2_key to {1, 1, 9'h175} (press up), horz=0 -> p1_csjudlr[3]=1 two cycles later. Release {0, 9'h175} -> 0. Repeat with horz=1 -> p1_csjudlr[0] (right) asserts instead.
- Press space, press ctrl, release space -> fire stays 1; release ctrl -> fire 0 two cycles later.
- COIN_LEN=4, GAP_LEN=3, START_LEN=5; pulse joystick_0[6] -> coin high exactly 4 cycles, 3 idle cycles, p2 start2 high exactly 5 cycles, p1 start1 never high; seq_busy high for 12 cycles.
- Same parameters, s1 and s2 rise in the same cycle -> start1 sequence only. A second s2 rise during GAP -> ignored; back in IDLE, seq_busy=0.
- Assert RESET asynchronously during START -> outputs 0 immediately; after release the FSM is IDLE and a new F1 press starts a full coin pulse.
